// File: rtl/mem_arb.sv
// Round-robin arbiter that shares one RAM/IO slave port among NUM_MASTERS bus masters.
// Defining MEM_ARB_DEBUG_LOCK_EN enables the dbg_lock_in pre-emption of the bus by master 0.

module mem_arb #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned RAM_ADDR_WIDTH = 17,
  parameter int unsigned BURST_MAX      = 16
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic [NUM_MASTERS-1:0]      m_req_in,
  input  logic [NUM_MASTERS-1:0]      m_wr_in,
  input  logic [NUM_MASTERS*32-1:0]   m_a_in,
  input  logic [NUM_MASTERS*8-1:0]    m_d_in,
  output logic [NUM_MASTERS-1:0]      m_gnt_out,
  output logic [NUM_MASTERS-1:0]      m_rvalid_out,
  output logic [7:0]                  m_d_out,
  output logic                        ram_en_out,
  output logic                        ram_r_nw_out,
  output logic [RAM_ADDR_WIDTH-1:0]   ram_a_out,
  output logic [7:0]                  ram_d_out,
  input  logic [7:0]                  ram_d_in,
  output logic                        io_en_out,
  output logic [2:0]                  io_sel_out,
  output logic                        io_wr_out,
  output logic [7:0]                  io_d_out,
  input  logic [7:0]                  io_d_in,
  input  logic                        dbg_lock_in
);

  localparam int unsigned IdxW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef logic [IdxW-1:0] idx_t;
  typedef enum logic [0:0] {StIdle, StOwn} state_e;

  state_e                 state_q;
  idx_t                   owner_q;
  idx_t                   ptr_q;
  logic [7:0]             burst_q;
  logic [NUM_MASTERS-1:0] gnt_q;
  logic [NUM_MASTERS-1:0] rvalid_q;
  logic                   rd_io_q;

  logic                   own_req;
  logic                   own_wr;
  logic [31:0]            own_a;
  logic [7:0]             own_d;
  logic [NUM_MASTERS-1:0] own_oh;
  logic [NUM_MASTERS-1:0] others;
  logic                   access;
  logic                   is_io;
  logic [8:0]             burst_inc;
  logic                   burst_hit;
  idx_t                   idle_pick;
  idx_t                   own_pick;
  logic                   lock_take;
  logic                   lock_hold;
  logic                   unused_bits;

  function automatic logic [NUM_MASTERS-1:0] to_onehot(input idx_t idx);
    logic [NUM_MASTERS-1:0] oh;
    oh = '0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      if (idx == idx_t'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  // First requester found searching upward from last+1, wrapping at NUM_MASTERS-1.
  function automatic idx_t rr_pick(input idx_t last, input logic [NUM_MASTERS-1:0] reqs);
    idx_t win;
    logic found;
    win   = last;
    found = 1'b0;
    for (int k = 1; k <= int'(NUM_MASTERS); k++) begin
      int c;
      c = (int'(last) + k) % int'(NUM_MASTERS);
      if (!found && reqs[c]) begin
        win   = idx_t'(c);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  always_comb begin
    own_req = 1'b0;
    own_wr  = 1'b0;
    own_a   = '0;
    own_d   = '0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      if (owner_q == idx_t'(i)) begin
        own_req = m_req_in[i];
        own_wr  = m_wr_in[i];
        own_a   = m_a_in[32*i +: 32];
        own_d   = m_d_in[8*i +: 8];
      end
    end
  end

  assign own_oh    = to_onehot(owner_q);
  assign others    = m_req_in & ~own_oh;
  assign access    = (state_q == StOwn) && own_req;
  assign is_io     = own_a[RAM_ADDR_WIDTH];
  assign burst_inc = {1'b0, burst_q} + 9'd1;
  assign burst_hit = burst_inc >= 9'(BURST_MAX);
  assign idle_pick = rr_pick(ptr_q, m_req_in);
  assign own_pick  = rr_pick(ptr_q, others);

  // Slave port is driven straight from the owner's request in the issuing cycle.
  assign ram_en_out   = access & ~is_io;
  assign io_en_out    = access & is_io;
  assign ram_r_nw_out = ~own_wr;
  assign ram_a_out    = ram_en_out ? own_a[RAM_ADDR_WIDTH-1:0] : '0;
  assign ram_d_out    = ram_en_out ? own_d : '0;
  assign io_sel_out   = io_en_out ? own_a[2:0] : '0;
  assign io_wr_out    = own_wr & io_en_out;
  assign io_d_out     = io_en_out ? own_d : '0;

  assign m_gnt_out    = gnt_q;
  assign m_rvalid_out = rvalid_q;
  assign m_d_out      = (|rvalid_q) ? (rd_io_q ? io_d_in : ram_d_in) : '0;

  assign unused_bits  = ^{dbg_lock_in, own_a};

`ifdef MEM_ARB_DEBUG_LOCK_EN
  logic lock_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      lock_q <= 1'b0;
    end else if (dbg_lock_in) begin
      lock_q <= 1'b1;
    end else if (lock_q && !m_req_in[0]) begin
      lock_q <= 1'b0;
    end
  end

  assign lock_take = dbg_lock_in;
  assign lock_hold = lock_q;
`else
  assign lock_take = 1'b0;
  assign lock_hold = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      ptr_q    <= idx_t'(NUM_MASTERS - 1);
      burst_q  <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      rd_io_q  <= 1'b0;
    end else begin
      // Read data returns one cycle after issue, independent of any ownership change.
      rvalid_q <= (access && !own_wr) ? own_oh : '0;
      if (access && !own_wr) rd_io_q <= is_io;

      if (lock_take) begin
        state_q <= StOwn;
        owner_q <= '0;
        ptr_q   <= '0;
        gnt_q   <= to_onehot('0);
        burst_q <= '0;
      end else if (lock_hold) begin
        if (!m_req_in[0]) begin
          state_q <= StIdle;
          gnt_q   <= '0;
          burst_q <= '0;
        end
      end else begin
        unique case (state_q)
          StIdle: begin
            if (|m_req_in) begin
              state_q <= StOwn;
              owner_q <= idle_pick;
              ptr_q   <= idle_pick;
              gnt_q   <= to_onehot(idle_pick);
              burst_q <= '0;
            end
          end
          StOwn: begin
            if (!own_req) begin
              state_q <= StIdle;
              gnt_q   <= '0;
              burst_q <= '0;
            end else if (burst_hit) begin
              if (|others) begin
                owner_q <= own_pick;
                ptr_q   <= own_pick;
                gnt_q   <= to_onehot(own_pick);
              end
              burst_q <= '0;
            end else begin
              burst_q <= burst_inc[7:0];
            end
          end
          default: begin
            state_q <= StIdle;
            gnt_q   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Directed, table-driven bench for mem_arb (2 masters, 17-bit RAM address, burst limit 4).

module tb_mem_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  m_req;
  logic [1:0]  m_wr;
  logic [63:0] m_a;
  logic [15:0] m_d;
  logic [1:0]  m_gnt;
  logic [1:0]  m_rvalid;
  logic [7:0]  m_dout;
  logic        ram_en;
  logic        ram_r_nw;
  logic [16:0] ram_a;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;
  logic        io_en;
  logic [2:0]  io_sel;
  logic        io_wr;
  logic [7:0]  io_dout;
  logic [7:0]  io_din;
  logic        dbg_lock;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arb #(
    .NUM_MASTERS   (2),
    .RAM_ADDR_WIDTH(17),
    .BURST_MAX     (4)
  ) dut (
    .clk_in      (clk),
    .rst_n_in    (rst_n),
    .m_req_in    (m_req),
    .m_wr_in     (m_wr),
    .m_a_in      (m_a),
    .m_d_in      (m_d),
    .m_gnt_out   (m_gnt),
    .m_rvalid_out(m_rvalid),
    .m_d_out     (m_dout),
    .ram_en_out  (ram_en),
    .ram_r_nw_out(ram_r_nw),
    .ram_a_out   (ram_a),
    .ram_d_out   (ram_dout),
    .ram_d_in    (ram_din),
    .io_en_out   (io_en),
    .io_sel_out  (io_sel),
    .io_wr_out   (io_wr),
    .io_d_out    (io_dout),
    .io_d_in     (io_din),
    .dbg_lock_in (dbg_lock)
  );

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  wr;
    logic [31:0] a0;
    logic [7:0]  d0;
    logic [7:0]  ram_d;
    logic [7:0]  io_d;
    logic [1:0]  gnt;
    logic [1:0]  rv;
    logic [7:0]  dout;
    logic        ram_en;
    logic [16:0] ram_a;
    logic        rnw;
    logic        io_en;
    logic [2:0]  io_sel;
    logic        io_wr;
    logic [7:0]  io_dout;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Master 1 always presents address 0x456 with zero write data.
  task automatic apply(input logic [1:0] req, input logic [1:0] wr, input logic [31:0] a0,
                       input logic [7:0] d0, input logic [7:0] rd, input logic [7:0] iod,
                       input logic dbg);
    @(posedge clk);
    #1;
    m_req    = req;
    m_wr     = wr;
    m_a      = {32'h0000_0456, a0};
    m_d      = {8'h00, d0};
    ram_din  = rd;
    io_din   = iod;
    dbg_lock = dbg;
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    m_req    = '0;
    m_wr     = '0;
    m_a      = '0;
    m_d      = '0;
    ram_din  = '0;
    io_din   = '0;
    dbg_lock = 1'b0;

    //          req    wr     a0            d0     ram_d  io_d   gnt    rv     dout   ren  ram_a         rnw  ioen sel   iowr io_d
    vecs[0]  = '{2'b11, 2'b00, 32'h00000010, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0, 17'h00000, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00};
    vecs[1]  = '{2'b11, 2'b00, 32'h00000010, 8'h00, 8'h00, 8'h00, 2'b01, 2'b00, 8'h00, 1'b1, 17'h00010, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00};
    vecs[2]  = '{2'b11, 2'b01, 32'h00030004, 8'h5A, 8'hC3, 8'h00, 2'b01, 2'b01, 8'hC3, 1'b0, 17'h00000, 1'b0, 1'b1, 3'd4, 1'b1, 8'h5A};
    vecs[3]  = '{2'b11, 2'b00, 32'h00020005, 8'h00, 8'h00, 8'h77, 2'b01, 2'b00, 8'h00, 1'b0, 17'h00000, 1'b1, 1'b1, 3'd5, 1'b0, 8'h00};
    vecs[4]  = '{2'b11, 2'b00, 32'h00000123, 8'h00, 8'h11, 8'h77, 2'b01, 2'b01, 8'h77, 1'b1, 17'h00123, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00};
    vecs[5]  = '{2'b11, 2'b00, 32'h00000123, 8'h00, 8'h22, 8'h00, 2'b10, 2'b01, 8'h22, 1'b1, 17'h00456, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00};
    vecs[6]  = '{2'b11, 2'b00, 32'h00000123, 8'h00, 8'h33, 8'h00, 2'b10, 2'b10, 8'h33, 1'b1, 17'h00456, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00};
    vecs[7]  = '{2'b11, 2'b00, 32'h00000123, 8'h00, 8'h44, 8'h00, 2'b10, 2'b10, 8'h44, 1'b1, 17'h00456, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00};
    vecs[8]  = '{2'b11, 2'b00, 32'h00000123, 8'h00, 8'h55, 8'h00, 2'b10, 2'b10, 8'h55, 1'b1, 17'h00456, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00};
    vecs[9]  = '{2'b10, 2'b00, 32'h00000123, 8'h00, 8'h66, 8'h00, 2'b01, 2'b10, 8'h66, 1'b0, 17'h00000, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00};
    vecs[10] = '{2'b10, 2'b00, 32'h00000123, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0, 17'h00000, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00};
    vecs[11] = '{2'b10, 2'b00, 32'h00000123, 8'h00, 8'h00, 8'h00, 2'b10, 2'b00, 8'h00, 1'b1, 17'h00456, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00};
    vecs[12] = '{2'b00, 2'b00, 32'h00000123, 8'h00, 8'h88, 8'h00, 2'b10, 2'b10, 8'h88, 1'b0, 17'h00000, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00};
    vecs[13] = '{2'b00, 2'b00, 32'h00000123, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0, 17'h00000, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00};
    vecs[14] = '{2'b01, 2'b00, 32'h00000123, 8'h00, 8'h00, 8'h00, 2'b00, 2'b00, 8'h00, 1'b0, 17'h00000, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00};
    vecs[15] = '{2'b01, 2'b00, 32'h00000123, 8'h00, 8'hA1, 8'h00, 2'b01, 2'b00, 8'h00, 1'b1, 17'h00123, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00};
    vecs[16] = '{2'b01, 2'b00, 32'h00000123, 8'h00, 8'hA2, 8'h00, 2'b01, 2'b01, 8'hA2, 1'b1, 17'h00123, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00};
    vecs[17] = '{2'b01, 2'b00, 32'h00000123, 8'h00, 8'hA3, 8'h00, 2'b01, 2'b01, 8'hA3, 1'b1, 17'h00123, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00};
    vecs[18] = '{2'b01, 2'b00, 32'h00000123, 8'h00, 8'hA4, 8'h00, 2'b01, 2'b01, 8'hA4, 1'b1, 17'h00123, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00};
    vecs[19] = '{2'b01, 2'b00, 32'h00000123, 8'h00, 8'hA5, 8'h00, 2'b01, 2'b01, 8'hA5, 1'b1, 17'h00123, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00};
    vecs[20] = '{2'b01, 2'b00, 32'h00000123, 8'h00, 8'hA6, 8'h00, 2'b01, 2'b01, 8'hA6, 1'b1, 17'h00123, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00};

    repeat (2) @(posedge clk);
    #1;
    chk("reset gnt", 32'(m_gnt), 32'h0);
    chk("reset rvalid", 32'(m_rvalid), 32'h0);
    chk("reset m_d", 32'(m_dout), 32'h0);
    chk("reset ram_en", 32'(ram_en), 32'h0);
    chk("reset io_en", 32'(io_en), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      apply(vecs[i].req, vecs[i].wr, vecs[i].a0, vecs[i].d0, vecs[i].ram_d, vecs[i].io_d, 1'b0);
      chk($sformatf("v%0d gnt", i), 32'(m_gnt), 32'(vecs[i].gnt));
      chk($sformatf("v%0d rvalid", i), 32'(m_rvalid), 32'(vecs[i].rv));
      chk($sformatf("v%0d m_d", i), 32'(m_dout), 32'(vecs[i].dout));
      chk($sformatf("v%0d ram_en", i), 32'(ram_en), 32'(vecs[i].ram_en));
      chk($sformatf("v%0d ram_a", i), 32'(ram_a), 32'(vecs[i].ram_a));
      chk($sformatf("v%0d ram_r_nw", i), 32'(ram_r_nw), 32'(vecs[i].rnw));
      chk($sformatf("v%0d io_en", i), 32'(io_en), 32'(vecs[i].io_en));
      chk($sformatf("v%0d io_sel", i), 32'(io_sel), 32'(vecs[i].io_sel));
      chk($sformatf("v%0d io_wr", i), 32'(io_wr), 32'(vecs[i].io_wr));
      chk($sformatf("v%0d io_d", i), 32'(io_dout), 32'(vecs[i].io_dout));
      chk($sformatf("v%0d ram_d_out", i), 32'(ram_dout), 32'h0);
    end

    // Reset in the same cycle a read is issued: grant and rvalid clear at once, no rvalid later.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst gnt", 32'(m_gnt), 32'h0);
    chk("async rst rvalid", 32'(m_rvalid), 32'h0);
    chk("async rst m_d", 32'(m_dout), 32'h0);
    chk("async rst ram_en", 32'(ram_en), 32'h0);
    @(posedge clk);
    #1;
    chk("rst hold rvalid", 32'(m_rvalid), 32'h0);
    chk("rst hold gnt", 32'(m_gnt), 32'h0);
    m_req   = 2'b11;
    m_wr    = 2'b00;
    m_a     = {32'h0000_0456, 32'h0000_0010};
    ram_din = 8'h3C;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    chk("post rst tie gnt", 32'(m_gnt), 32'h1);
    chk("post rst ram_en", 32'(ram_en), 32'h1);
    chk("post rst ram_a", 32'(ram_a), 32'h10);

    // Master 0 finishes a burst of 4, master 1 takes over, then dbg_lock_in pulses.
    for (int k = 0; k < 3; k++) begin
      apply(2'b11, 2'b00, 32'h0000_0010, 8'h00, 8'h3C, 8'h00, 1'b0);
      chk($sformatf("m0 burst %0d gnt", k), 32'(m_gnt), 32'h1);
      chk($sformatf("m0 burst %0d rvalid", k), 32'(m_rvalid), 32'h1);
      chk($sformatf("m0 burst %0d m_d", k), 32'(m_dout), 32'h3C);
    end
    apply(2'b11, 2'b00, 32'h0000_0010, 8'h00, 8'h3C, 8'h00, 1'b0);
    chk("m1 first gnt", 32'(m_gnt), 32'h2);
    chk("m1 first ram_a", 32'(ram_a), 32'h456);
    apply(2'b11, 2'b00, 32'h0000_0010, 8'h00, 8'h3C, 8'h00, 1'b1);
    chk("dbg pulse gnt", 32'(m_gnt), 32'h2);
    apply(2'b11, 2'b00, 32'h0000_0010, 8'h00, 8'h9C, 8'h00, 1'b0);
`ifdef MEM_ARB_DEBUG_LOCK_EN
    chk("dbg preempt gnt", 32'(m_gnt), 32'h1);
`else
    chk("dbg ignored gnt", 32'(m_gnt), 32'h2);
`endif
    chk("dbg inflight rvalid", 32'(m_rvalid), 32'h2);
    chk("dbg inflight m_d", 32'(m_dout), 32'h9C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of bus masters (2..8).
REQ-002 SHALL have parameter RAM_ADDR_WIDTH, default 17, RAM address width; address bit RAM_ADDR_WIDTH selects IO.
REQ-003 SHALL have parameter BURST_MAX, default 16, maximum consecutive accesses per ownership when others are requesting.
REQ-004 SHALL have ports: clk_in input 1 system clock; rst_n_in input 1 reset, asynchronous, active-low.
REQ-005 SHALL have ports: m_req_in input NUM_MASTERS access request; m_wr_in input NUM_MASTERS 1=write; m_a_in input NUM_MASTERS*32 addresses, master i at [32i+31:32i]; m_d_in input NUM_MASTERS*8 write data, master i at [8i+7:8i].
REQ-006 SHALL have ports: m_gnt_out output NUM_MASTERS one-hot grant; m_rvalid_out output NUM_MASTERS read-data valid; m_d_out output 8 shared read data.
REQ-007 SHALL have ports: ram_en_out output 1; ram_r_nw_out output 1 (1=read); ram_a_out output RAM_ADDR_WIDTH; ram_d_out output 8; ram_d_in input 8.
REQ-008 SHALL have ports: io_en_out output 1; io_sel_out output 3 (address[2:0]); io_wr_out output 1; io_d_out output 8; io_d_in input 8.
REQ-009 SHALL have port dbg_lock_in input 1 debug lock request for master 0.

Function
REQ-010 SHALL implement states IDLE and OWN, plus a registered owner index and a round-robin pointer holding the last owner.
REQ-011 IDLE with any m_req_in bit set SHALL enter OWN next cycle with m_gnt_out one-hot on the winner: first requester searching upward from pointer+1, wrapping at NUM_MASTERS-1.
REQ-012 In OWN, each cycle owner's m_req_in=1 SHALL issue exactly one access, driving the slave ports combinationally from the owner's address, wr and data.
REQ-013 Address bit RAM_ADDR_WIDTH=0 SHALL assert ram_en_out; =1 SHALL assert io_en_out; never both; neither is asserted when no access is issued.
REQ-014 ram_r_nw_out SHALL equal ~wr; io_wr_out SHALL equal wr AND io_en_out.
REQ-015 A read issued in cycle T SHALL assert m_rvalid_out for the issuing master only in T+1, with m_d_out = ram_d_in or io_d_in per the region registered at T; writes produce no rvalid.
REQ-016 Owner's m_req_in=0 in OWN SHALL return to IDLE; m_gnt_out is zero the following cycle; pending rvalid still delivered.
REQ-017 An 8-bit burst counter SHALL count issued accesses; reaching BURST_MAX with another master requesting SHALL re-arbitrate so the new owner is granted the next cycle with no idle gap.
REQ-018 Reaching BURST_MAX with no other requester SHALL keep ownership and clear the counter; the counter also clears on every ownership change.
REQ-019 Non-owner requests SHALL be held off (gnt=0) without loss; a requester that keeps m_req_in high is granted within (NUM_MASTERS-1)*BURST_MAX+NUM_MASTERS cycles.
REQ-020 The round-robin pointer SHALL update to the winner on every grant.

Reset
REQ-021 rst_n_in low SHALL immediately force state IDLE, m_gnt_out=0, m_rvalid_out=0, m_d_out=0, burst counter 0, pointer NUM_MASTERS-1 (master 0 wins first tie).
REQ-022 Reset mid-access SHALL drop any pending rvalid; ram_en_out and io_en_out SHALL be 0 while reset is asserted.

Configuration
REQ-023 Macro MEM_ARB_DEBUG_LOCK_EN defined: dbg_lock_in=1 SHALL pre-empt the current owner at the next clock edge, granting master 0 regardless of burst counter; ownership held until both dbg_lock_in=0 and m_req_in[0]=0; pre-empted owner's in-flight rvalid still delivered.
REQ-024 Macro MEM_ARB_DEBUG_LOCK_EN undefined: dbg_lock_in SHALL be ignored and master 0 arbitrates round-robin like all others.

Verification
REQ-025 Reset release, req=2'b11 -> gnt=2'b01 one cycle later; master 0 read 0x00000010 -> ram_en_out=1, ram_a_out=0x00010, rvalid[0]=1 next cycle with ram_d_in value.
REQ-026 Owner writes 0x00030004 data 0x5A -> io_en_out=1, io_sel_out=3'b100, io_wr_out=1, io_d_out=0x5A, ram_en_out=0, no rvalid.
REQ-027 BURST_MAX=4, both masters continuously requesting -> grant alternates every 4 accesses, no idle cycle between owners.
REQ-028 MEM_ARB_DEBUG_LOCK_EN defined, master 1 mid-burst, dbg_lock_in pulsed 1 -> gnt=2'b01 next cycle; master 1's last read rvalid still arrives.
REQ-029 rst_n_in low in cycle after a read issue -> rvalid stays 0, gnt=0 asynchronously; first post-reset tie goes to master 0.
